// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified memory arbiter.
//   MEM_BYTE/MEM_HALF/MEM_WORD : memSize codes understood by DataMemory
//   arb_state_t                : arbiter sequence IDLE -> ACCESS -> RESP
//   owner_t                    : which requester owns the current access
package mips_mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        IF,
        D
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the unified memory arbiter.
// Ports:
//   d_req    in   data request pending
//   if_req   in   fetch request pending
//   wait_cnt in   consecutive data grants made while fetch was waiting
//   owner    out  winner (NONE when nobody requests)
module mem_arb_pick
    import mips_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 2,
    parameter int unsigned CW       = 2
) (
    input  logic          d_req,
    input  logic          if_req,
    input  logic [CW-1:0] wait_cnt,
    output owner_t        owner
);

    always_comb begin
        owner = NONE;
        // Data yields only when fetch is actually waiting; a saturated
        // counter with no fetch request must not stall the data side.
        if (d_req && ((wait_cnt < CW'(MAX_WAIT)) || !if_req)) begin
            owner = D;
        end else if (if_req) begin
            owner = IF;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port DataMemory between instruction fetch and load/store.
// Each access runs GRANT (in IDLE) -> ACCESS -> RESP; data has priority but
// fetch is forced through after MAX_WAIT consecutive lost arbitrations.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   if_req/if_addr               fetch request, held until if_ready
//   if_ready/if_rdata            one-cycle pulse with fetched word
//   d_req/d_addr/d_wdata/d_we/d_size/d_sign   data request, held until d_ready
//   d_ready/d_rdata              one-cycle pulse: store done / load data
//   mem_addr/mem_din/mem_write/mem_read/mem_size/mem_sign  to DataMemory
//   mem_dout                     combinational read data from DataMemory
module unified_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_sign,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_write,
    output logic        mem_read,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_dout
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    arb_state_t    state;
    owner_t        owner;
    owner_t        pick;
    logic [CW-1:0] wait_cnt;

    mem_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_pick (
        .d_req    (d_req),
        .if_req   (if_req),
        .wait_cnt (wait_cnt),
        .owner    (pick)
    );

    // The registered mem_* outputs double as the latched request: loaded on
    // grant, used during ACCESS, cleared on leaving it. Async reset therefore
    // drops mem_write immediately, aborting an in-flight store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= NONE;
            wait_cnt  <= '0;
            if_ready  <= 1'b0;
            if_rdata  <= '0;
            d_ready   <= 1'b0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_size  <= '0;
            mem_sign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick == D) begin
                        owner     <= D;
                        state     <= ACCESS;
                        mem_addr  <= d_addr;
                        mem_din   <= d_wdata;
                        mem_write <= d_we;
                        mem_read  <= ~d_we;
                        mem_size  <= d_size;
                        mem_sign  <= d_sign & ~d_we;
                        if (if_req && (wait_cnt != CW'(MAX_WAIT))) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else if (pick == IF) begin
                        owner     <= IF;
                        state     <= ACCESS;
                        mem_addr  <= if_addr;
                        mem_din   <= '0;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_size  <= MEM_WORD;
                        mem_sign  <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                ACCESS: begin
                    if (owner == IF) begin
                        if_rdata <= mem_dout;
                        if_ready <= 1'b1;
                    end else begin
                        if (mem_read) begin
                            d_rdata <= mem_dout;
                        end
                        d_ready <= 1'b1;
                    end
                    mem_addr  <= '0;
                    mem_din   <= '0;
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_size  <= '0;
                    mem_sign  <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    owner    <= NONE;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter with a byte-addressed,
// little-endian DataMemory stand-in behind mem_* and an independent
// reference memory plus arbitration-order model.
module tb_unified_mem_arbiter;

    localparam int unsigned MAX_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'b11;
    logic        d_sign = 1'b0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_sign    (d_sign),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_size  (mem_size),
        .mem_sign  (mem_sign),
        .mem_dout  (mem_dout)
    );

    // DataMemory stand-in: 256 bytes, little-endian, write on clock edge.
    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [7:0]  ra;
    logic [31:0] rw;

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_din[7:0];
            if (mem_size != 2'b01) mem[mem_addr[7:0] + 8'd1] <= mem_din[15:8];
            if (mem_size == 2'b11) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_din[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_din[31:24];
            end
        end
    end

    assign ra = mem_addr[7:0];
    assign rw = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

    always_comb begin
        case (mem_size)
            2'b01:   mem_dout = {{24{mem_sign & rw[7]}}, rw[7:0]};
            2'b10:   mem_dout = {{16{mem_sign & rw[15]}}, rw[15:0]};
            default: mem_dout = rw;
        endcase
    end

    // Reference memory, updated only when a store is acknowledged.
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int unsigned n = nbytes(sz);
        logic [63:0] v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (64'(ref_mem[8'(a + i)]) << (8 * i));
        if (sg && n < 4 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int unsigned n = nbytes(sz);
        for (int unsigned i = 0; i < n; i++) ref_mem[8'(a + i)] = wd[8 * i +: 8];
    endtask

    task automatic d_access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                            input logic [1:0] sz, input logic sg,
                            output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        d_addr = a; d_wdata = wd; d_we = we; d_size = sz; d_sign = sg; d_req = 1'b1;
        lat = 0;
        @(negedge clk);
        while (d_ready !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = d_rdata;
        if (lat < 20 && we) ref_store(a, sz, wd);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic if_access(input logic [31:0] a, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        if_addr = a; if_req = 1'b1;
        lat = 0;
        @(negedge clk);
        while (if_ready !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = if_rdata;
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_ready, d_ready, mem_write, mem_read} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {if_ready, d_ready, mem_write, mem_read});
        end
        checks++;
        if ((if_rdata | d_rdata | mem_addr | mem_din) !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got if_rdata=%h d_rdata=%h mem_addr=%h mem_din=%h expected 0",
                     if_rdata, d_rdata, mem_addr, mem_din);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        d_addr = 32'h0; d_wdata = 32'h1234_5678; d_we = 1'b1; d_size = 2'b11; d_sign = 1'b0; d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h0 || mem_din !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_access_drive: got we=%b rd=%b addr=%h din=%h expected we=1 rd=0 addr=0 din=12345678",
                     mem_write, mem_read, mem_addr, mem_din);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_abort: got mem_write=%b expected 0", mem_write);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b0 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_ready: got d_ready=%b if_ready=%b expected 0 0", d_ready, if_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        d_access(32'h0, 32'h0, 1'b0, 2'b11, 1'b0, rd, lat);
        checks++;
        if (rd !== ref_load(32'h0, 2'b11, 1'b0) || lat != 2) begin
            errors++;
            $display("FAIL reset_store_aborted: got data=%h lat=%0d expected data=%h lat=2",
                     rd, lat, ref_load(32'h0, 2'b11, 1'b0));
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        int lat;
        d_access(32'h0, 32'h1234_5678, 1'b1, 2'b11, 1'b0, rd, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL sw_latency: got %0d expected 2", lat);
        end
        d_access(32'h0, 32'h0, 1'b0, 2'b11, 1'b0, rd, lat);
        checks++;
        if (rd !== 32'h1234_5678 || lat != 2) begin
            errors++;
            $display("FAIL lw_data: got %h lat=%0d expected 12345678 lat=2", rd, lat);
        end
    endtask

    task automatic test_subword();
        logic [31:0] rd;
        int lat;
        d_access(32'h4, 32'h1234_5678, 1'b1, 2'b11, 1'b0, rd, lat);
        d_access(32'h6, 32'h0000_00FF, 1'b1, 2'b01, 1'b0, rd, lat);
        d_access(32'h5, 32'h0, 1'b0, 2'b10, 1'b1, rd, lat);
        checks++;
        if (rd !== 32'hFFFF_FF56) begin
            errors++;
            $display("FAIL lh_signed: got %h expected ffffff56", rd);
        end
        d_access(32'h5, 32'h0, 1'b0, 2'b10, 1'b0, rd, lat);
        checks++;
        if (rd !== 32'h0000_FF56) begin
            errors++;
            $display("FAIL lh_unsigned: got %h expected 0000ff56", rd);
        end
        if_access(32'h4, rd, lat);
        checks++;
        if (rd !== 32'h12FF_5678 || lat != 2) begin
            errors++;
            $display("FAIL fetch_word: got %h lat=%0d expected 12ff5678 lat=2", rd, lat);
        end
    endtask

    task automatic test_idle_hold();
        int pulses = 0;
        int first = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_read, mem_write, if_ready, d_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_quiet: got rd/wr/ifr/dr=%b expected 0000", {mem_read, mem_write, if_ready, d_ready});
            end
        end
        @(posedge clk); #1;
        if_addr = 32'h4; if_req = 1'b1;
        @(negedge clk);
        if (if_ready === 1'b1) begin pulses++; first = 0; end
        @(posedge clk); #1;
        if_req = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            if (if_ready === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (pulses != 1 || first != 2) begin
            errors++;
            $display("FAIL dropped_req_ready: got pulses=%0d at=%0d expected pulses=1 at=2", pulses, first);
        end
        checks++;
        if (if_rdata !== ref_load(32'h4, 2'b11, 1'b0)) begin
            errors++;
            $display("FAIL dropped_req_data: got %h expected %h", if_rdata, ref_load(32'h4, 2'b11, 1'b0));
        end
    endtask

    // Both sides keep requesting back-to-back; the model walks the priority
    // rules one arbitration at a time, each arbitration consuming 3 cycles.
    task automatic test_mix(input string name, input int d_n, input int if_n, input int w0);
        int exp_cyc[$];
        bit exp_who[$];
        int got_cyc[$];
        bit got_who[$];
        int dl = d_n;
        int il = if_n;
        int w = w0;
        int t = 0;
        int c = 0;
        while (dl > 0 || il > 0) begin
            if (dl > 0 && (w < int'(MAX_WAIT) || il == 0)) begin
                exp_who.push_back(1'b1);
                if (il > 0) w++;
                dl--;
            end else begin
                exp_who.push_back(1'b0);
                w = 0;
                il--;
            end
            exp_cyc.push_back(t + 2);
            t += 3;
        end
        dl = d_n;
        il = if_n;
        d_addr = 32'h8; d_we = 1'b0; d_size = 2'b11; d_sign = 1'b0;
        if_addr = 32'h4;
        while ((dl > 0 || il > 0) && c < 100) begin
            @(posedge clk); #1;
            d_req = (dl > 0);
            if_req = (il > 0);
            @(negedge clk);
            if (d_ready === 1'b1) begin
                got_who.push_back(1'b1); got_cyc.push_back(c); dl--;
                checks++;
                if (d_rdata !== ref_load(32'h8, 2'b11, 1'b0)) begin
                    errors++;
                    $display("FAIL %s_d_data: got %h expected %h", name, d_rdata, ref_load(32'h8, 2'b11, 1'b0));
                end
            end
            if (if_ready === 1'b1) begin
                got_who.push_back(1'b0); got_cyc.push_back(c); il--;
                checks++;
                if (if_rdata !== ref_load(32'h4, 2'b11, 1'b0)) begin
                    errors++;
                    $display("FAIL %s_if_data: got %h expected %h", name, if_rdata, ref_load(32'h4, 2'b11, 1'b0));
                end
            end
            c++;
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        if_req = 1'b0;
        checks++;
        if (got_who.size() != exp_who.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d services expected %0d", name, got_who.size(), exp_who.size());
        end else begin
            for (int i = 0; i < exp_who.size(); i++) begin
                checks++;
                if (got_who[i] != exp_who[i] || got_cyc[i] != exp_cyc[i]) begin
                    errors++;
                    $display("FAIL %s_order[%0d]: got %s@%0d expected %s@%0d", name, i,
                             got_who[i] ? "D" : "IF", got_cyc[i], exp_who[i] ? "D" : "IF", exp_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit d_fin = 1'b0;
        bit i_fin = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int t = 0;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk); #1;
                    d_addr = 32'($urandom_range(0, 63));
                    d_we = 1'($urandom_range(0, 1));
                    d_size = 2'($urandom_range(1, 3));
                    d_sign = 1'($urandom_range(0, 1));
                    d_wdata = $urandom;
                    d_req = 1'b1;
                    @(negedge clk);
                    while (d_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
                    if (t >= 50) begin
                        checks++; errors++;
                        $display("FAIL rand_d_timeout: got no d_ready expected within 50 cycles");
                    end
                    @(posedge clk); #1;
                    d_req = 1'b0;
                end
                d_fin = 1'b1;
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    int t = 0;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk); #1;
                    if_addr = 32'($urandom_range(0, 63));
                    if_req = 1'b1;
                    @(negedge clk);
                    while (if_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
                    if (t >= 50) begin
                        checks++; errors++;
                        $display("FAIL rand_if_timeout: got no if_ready expected within 50 cycles");
                    end
                    @(posedge clk); #1;
                    if_req = 1'b0;
                end
                i_fin = 1'b1;
            end
            begin
                int guard = 0;
                logic pd = 1'b0;
                logic pi = 1'b0;
                while (!(d_fin && i_fin) && guard < 5000) begin
                    @(negedge clk);
                    guard++;
                    checks++;
                    if (mem_write === 1'b1 && mem_read === 1'b1) begin
                        errors++;
                        $display("FAIL rand_rw_exclusive: got read=1 write=1 expected at most one");
                    end
                    if (d_ready === 1'b1) begin
                        checks++;
                        if (pd === 1'b1) begin
                            errors++;
                            $display("FAIL rand_d_pulse: got d_ready high 2 cycles expected 1");
                        end
                        if (d_we) begin
                            ref_store(d_addr, d_size, d_wdata);
                        end else begin
                            checks++;
                            if (d_rdata !== ref_load(d_addr, d_size, d_sign)) begin
                                errors++;
                                $display("FAIL rand_load @%h sz=%b sg=%b: got %h expected %h",
                                         d_addr, d_size, d_sign, d_rdata, ref_load(d_addr, d_size, d_sign));
                            end
                        end
                    end
                    if (if_ready === 1'b1) begin
                        checks++;
                        if (pi === 1'b1 || if_rdata !== ref_load(if_addr, 2'b11, 1'b0)) begin
                            errors++;
                            $display("FAIL rand_fetch @%h: got %h prev_ready=%b expected %h prev_ready=0",
                                     if_addr, if_rdata, pi, ref_load(if_addr, 2'b11, 1'b0));
                        end
                    end
                    pd = d_ready;
                    pi = if_ready;
                end
                if (guard >= 5000) begin
                    checks++; errors++;
                    $display("FAIL rand_timeout: got unfinished traffic expected completion in 5000 cycles");
                end
            end
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_store_load();
        test_subword();
        test_idle_hold();
        test_mix("contention", 1, 1, 0);
        test_mix("starvation", 4, 1, 0);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
